// File: rtl/fsmd_feeder.sv
// fsmd_feeder: operand FIFO that feeds a start/done datapath FSMD one pair at a time
// and holds each captured result until the consumer takes it.
module fsmd_feeder #(
   parameter int DEPTH = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_x,
   input  logic [3:0]               in_y,
   output logic                     start,
   output logic [3:0]               xin,
   output logic [3:0]               yin,
   input  logic                     done,
   input  logic [7:0]               result,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, state_nx;
   logic [3:0]    mem_x [DEPTH];
   logic [3:0]    mem_y [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] wait_cnt;
   logic          done_q, done_rise, push, pop, timed_out;

   assign in_ready  = ~rst & (count < (AW+1)'(DEPTH));
   assign push      = in_valid & in_ready;
   assign pop       = state == ISSUE;
   // only a fresh edge completes an op, so a level left over from the previous op is ignored
   assign done_rise = done & ~done_q;
   assign timed_out = wait_cnt == TW'(TIMEOUT - 1);

   always_comb begin
      state_nx = state;
      state_nx = state == IDLE  ? ((count != '0 && !out_valid) ? ISSUE : IDLE)
               : state == ISSUE ? WAIT
               : ((done_rise || timed_out) ? IDLE : WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         start     <= 1'b0;
         xin       <= '0;
         yin       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
         done_q    <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state    <= state_nx;
         done_q   <= done;
         start    <= state_nx == ISSUE;
         if (state_nx == ISSUE) begin
            xin <= mem_x[rd_ptr];
            yin <= mem_y[rd_ptr];
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
         if (state == WAIT && done_rise) begin
            out_data  <= result;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (state == WAIT && !done_rise && timed_out) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_x[wr_ptr] <= in_x;
         mem_y[wr_ptr] <= in_y;
      end
   end
endmodule

// File: tb/tb_fsmd_feeder.sv
// tb_fsmd_feeder: directed vectors, corner sequences and a randomized scoreboard run
// against a behavioural model of the downstream FSMD.
module tb_fsmd_feeder;
   localparam int DEPTH = 4;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, start, out_valid, out_ready, err;
   logic [3:0] in_x, in_y, xin, yin;
   logic [7:0] out_data;
   logic [2:0] count;
   logic       done = 1'b0;
   logic [7:0] result = 8'h00;

   int tests = 0, fails = 0, nstart = 0;
   logic scb = 1'b0, late = 1'b0, never = 1'b0;
   logic [3:0] qx[$], qy[$];
   logic [7:0] expq[$];

   always #5 clk = ~clk;

   fsmd_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .start(start), .xin(xin), .yin(yin),
      .done(done), .result(result), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .count(count), .err(err)
   );

   function automatic logic [7:0] f(input logic [3:0] x, input logic [3:0] y);
      int xi, yi;
      xi = int'(x);
      yi = int'(y);
      if (xi == 0) return 8'h00;
      return 8'((2 * xi) / 3 - (yi / 3) / (xi * xi));
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [3:0] x, input logic [3:0] y);
      in_valid = 1'b1;
      in_x = x;
      in_y = y;
      tick();
      in_valid = 1'b0;
   endtask

   // downstream FSMD: done drops when start is sampled (or two cycles later in late mode), rises 4 cycles after start
   int fc = 0;
   logic [3:0] mx, my;
   always @(posedge clk) begin
      if (start) begin
         mx <= xin;
         my <= yin;
         fc <= 1;
         if (!late) done <= 1'b0;
      end else if (fc != 0) begin
         fc <= (fc == 4) ? 0 : fc + 1;
         if (fc == 2 && late) done <= 1'b0;
         if (fc == 4 && !never) begin
            done <= 1'b1;
            result <= f(mx, my);
         end
      end
   end

   // scoreboard: FIFO order of issued pairs and of results handed to the consumer
   always @(negedge clk) begin
      if (start) nstart++;
      if (scb && !rst) begin
         chk("m_count", 32'(count), qx.size());
         chk("m_in_ready", 32'(in_ready), 32'(qx.size() < DEPTH));
         if (start) begin
            chk("m_issue_nonempty", 32'(qx.size() != 0), 1);
            if (qx.size() != 0) begin
               chk("m_xin", 32'(xin), 32'(qx[0]));
               chk("m_yin", 32'(yin), 32'(qy[0]));
               expq.push_back(f(qx[0], qy[0]));
               void'(qx.pop_front());
               void'(qy.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            qx.push_back(in_x);
            qy.push_back(in_y);
         end
         if (out_valid && out_ready) begin
            chk("m_result_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) chk("m_result", 32'(out_data), 32'(expq.pop_front()));
         end
      end
   end

   typedef struct {
      logic [3:0] x, y;
      logic [7:0] data;
      int         lat;
      logic       late;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] sx, sy;
      logic [7:0] od;
      int lat, t0, ns, errt, ns0;
      logic got, ov;
      vecs[0] = '{4'd3,  4'd9,  8'h02, 6, 1'b0};
      vecs[1] = '{4'd2,  4'd4,  8'h01, 6, 1'b1};
      vecs[2] = '{4'd7,  4'd1,  8'h04, 6, 1'b0};
      vecs[3] = '{4'd1,  4'd15, 8'hFB, 6, 1'b0};
      vecs[4] = '{4'd15, 4'd15, 8'h0A, 6, 1'b0};
      vecs[5] = '{4'd5,  4'd6,  8'h03, 6, 1'b0};

      rst = 1'b1; in_valid = 1'b1; in_x = 4'd7; in_y = 4'd7; out_ready = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      tick();
      @(negedge clk);
      chk("rst_count", 32'(count), 0);
      chk("rst_start", 32'(start), 0);
      chk("rst_xy", {24'd0, xin, yin}, 0);
      chk("rst_out", {23'd0, out_valid, out_data}, 0);
      chk("rst_err", 32'(err), 0);
      in_valid = 1'b0;
      rst = 1'b0;
      tick();

      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         late = vecs[k].late;
         push1(vecs[k].x, vecs[k].y);
         ns = 0; lat = -1; t0 = 0; sx = 0; sy = 0; od = 0;
         for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (start) begin ns++; t0 = i; sx = xin; sy = yin; end
            if (out_valid) begin lat = i - t0; od = out_data; end
         end
         chk("vec_xin", 32'(sx), 32'(vecs[k].x));
         chk("vec_yin", 32'(sy), 32'(vecs[k].y));
         chk("vec_starts", ns, 1);
         chk("vec_data", 32'(od), 32'(vecs[k].data));
         chk("vec_latency", lat, vecs[k].lat);
         tick();
         @(negedge clk);
         chk("vec_ov_one_cycle", 32'(out_valid), 0);
         late = 1'b0;
         tick();
      end

      out_ready = 1'b0;
      scb = 1'b1;
      ns0 = nstart;
      for (int k = 0; k < 5; k++) push1(4'(k + 1), 4'(2 * k + 1));
      repeat (12) tick();
      @(negedge clk);
      chk("bb_count_full", 32'(count), DEPTH);
      chk("bb_in_ready_full", 32'(in_ready), 0);
      chk("bb_out_valid", 32'(out_valid), 1);
      chk("bb_single_issue", nstart - ns0, 1);
      in_valid = 1'b1; in_x = 4'hE; in_y = 4'hE;
      tick();
      @(negedge clk);
      chk("full_no_push", 32'(count), DEPTH);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (start) got = 1'b1;
      end
      chk("fp_issue", 32'(got), 1);
      chk("fp_in_ready", 32'(in_ready), 0);
      chk("fp_count_pre", 32'(count), DEPTH);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("fp_count_post", 32'(count), DEPTH - 1);
      out_ready = 1'b1;
      repeat (80) tick();
      chk("bb_drain_ops", qx.size(), 0);
      chk("bb_drain_results", expq.size(), 0);
      scb = 1'b0;

      never = 1'b1;
      push1(4'd5, 4'd5);
      push1(4'd6, 4'd6);
      t0 = -1; errt = -1; ov = 1'b0;
      for (int i = 0; i < 60 && errt < 0; i++) begin
         @(negedge clk);
         if (start && t0 < 0) t0 = i;
         if (out_valid) ov = 1'b1;
         if (err) errt = i - t0;
      end
      chk("to_err_latency", errt, TIMEOUT + 1);
      chk("to_no_capture", 32'(ov), 0);
      never = 1'b0;
      lat = -1; sx = 0; sy = 0; od = 0;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         @(negedge clk);
         if (start) begin sx = xin; sy = yin; end
         if (out_valid) begin lat = i; od = out_data; end
      end
      chk("to_next_xin", 32'(sx), 6);
      chk("to_next_yin", 32'(sy), 6);
      chk("to_next_data", 32'(od), 32'h04);
      chk("to_err_sticky", 32'(err), 1);
      tick();

      push1(4'd3, 4'd3);
      push1(4'd4, 4'd4);
      push1(4'd5, 4'd5);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (start) got = 1'b1;
      end
      chk("ra_issue", 32'(got), 1);
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("ra_in_ready", 32'(in_ready), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("ra_count", 32'(count), 0);
      chk("ra_xy_start", {23'd0, start, xin, yin}, 0);
      chk("ra_out", {23'd0, out_valid, out_data}, 0);
      chk("ra_err", 32'(err), 0);
      ov = 1'b0;
      ns0 = nstart;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) ov = 1'b1;
      end
      chk("ra_late_done_ignored", 32'(ov), 0);
      chk("ra_no_issue", nstart - ns0, 0);

      tick();
      scb = 1'b1;
      repeat (800) begin
         in_valid = 1'($urandom);
         in_x = 4'($urandom_range(1, 15));
         in_y = 4'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (80) tick();
      chk("rand_drain_ops", qx.size(), 0);
      chk("rand_drain_results", expq.size(), 0);
      chk("rand_no_err", 32'(err), 0);
      scb = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
